timer_entry: RTL and testbench
==============================

# timer_entry

Keypad entry stage for the microwave timer. It debounces the ten decimal key lines and shifts accepted digits into a three-digit buffer (minutes, tens of seconds, units of seconds). On a start request it validates the entry and drives the parallel `data` buses and the active-low `loadn` strobe of the downstream down-counter digits (mod6 tens-of-seconds, mod10 units/minutes). It sits directly upstream of the timer counter chain.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable cycles required before a key is accepted; legal range 1–15.
- `clk` input 1: single clock, rising edge.
- `clrn` input 1: asynchronous, active-low reset.
- `keys` input 10: raw key lines, bit *n* = digit *n*, active high.
- `start` input 1: start request, level; rising edge acts.
- `cancel` input 1: synchronous clear of the entry, active high.
- `entry_en` input 1: 1 = timer idle, entry allowed; 0 = keys and start ignored.
- `sec_ones` output 4: units-of-seconds digit, 0–9.
- `sec_tens` output 4: tens-of-seconds digit, 0–9 while held; load is refused unless ≤5.
- `mins` output 4: minutes digit, 0–9.
- `loadn` output 1: active-low one-cycle load strobe to the counter digits.
- `err` output 1: one-cycle pulse, start refused because `sec_tens` > 5.

## Operation
- FSM states: IDLE, DEBOUNCE, HELD, LOAD.
- IDLE: when `keys` is one-hot and `entry_en`=1, go to DEBOUNCE and latch the code. Zero keys or multiple keys: stay.
- DEBOUNCE: per-cycle counter. If `keys` differs from the latched code, or `entry_en`=0, return to IDLE. Once the code has been sampled identical on `DEBOUNCE_CYCLES` consecutive edges, shift it in at that edge and go to HELD.
- Shift: `mins`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←digit. The old `mins` is discarded. The 2-bit digit count saturates at 3.
- HELD: wait until `keys`==0, then go to IDLE. One press yields exactly one digit.
- Start: a rising edge of `start` (registered `start_q`) in IDLE with `entry_en`=1:
  - `sec_tens` > 5: pulse `err`, keep the buffer, stay in IDLE.
  - All digits 0: ignore.
  - Otherwise: go to LOAD.
- A `start` edge in any state other than IDLE is dropped.
- LOAD: `loadn`=0 for exactly one cycle with the buffer stable, then clear the buffer and count to 0 and return to IDLE.
- `cancel` has priority over everything except reset: clear the buffer and count, force IDLE, `loadn`=1, no `err`.
  - `cancel` in the LOAD cycle does not abort the strobe already driven.
  - It clears the buffer at the same edge.

## Timing
- Reset values: `sec_ones`=`sec_tens`=`mins`=0, `loadn`=1, `err`=0, state IDLE, count 0, `start_q`=0, debounce counter 0.
- All outputs are registered. No combinational path from input to output.
- Key latency: if the first stable sample is at edge *k*, the digit appears on the buses after edge *k*+`DEBOUNCE_CYCLES`−1.
- Start latency:
  - `start` rises and is sampled at edge *k*.
  - `loadn` falls after edge *k* and rises after edge *k*+1.
  - The downstream counters sample data at edge *k*+1.
  - The buffer reads 0 after edge *k*+1.
- `err`: high for the single cycle after edge *k*.
- `start` held high generates one event only. It must drop low for at least one sampled cycle to re-arm.
- Key and start in the same IDLE cycle: start wins and the key sequence restarts from IDLE afterwards.
- Asynchronous `clrn` mid-LOAD: `loadn` returns to 1 immediately.

## Configuration
- `TIMER_ENTRY_LOCK_EN` defined: when the digit count is 3, further accepted keys are discarded (buffer unchanged) until a load or cancel.
- Undefined: a fourth and later digit shift in and drop the old `mins`, as described in Operation.

## Test plan
- Reset, press 1, 3, 0 (each held 6 cycles, released), pulse start → `mins`=1, `sec_tens`=3, `sec_ones`=0; `loadn` low exactly 1 cycle, one cycle after the start edge; all digits 0 afterwards.
- Key 5 glitching for 2 cycles with `DEBOUNCE_CYCLES`=4 → no digit shifted. Key 5 held 4 cycles → `sec_ones`=5 exactly once, even if held for 100 cycles.
- Enter 1, 7, 5 then start → `err` pulse of 1 cycle, `loadn` stays 1, buffer 1/7/5 retained. `cancel` → all 0.
- Keys 2 and 3 pressed together, and `entry_en`=0 with key 4 → buffer unchanged. Start with an empty buffer → no `loadn`, no `err`.
- Enter 9, 8, 4, 2:
  - Without the macro → `mins`=8, `sec_tens`=4, `sec_ones`=2.
  - With `TIMER_ENTRY_LOCK_EN` → 9/8/4.
- `clrn` asserted during the LOAD cycle → `loadn`=1 and all digits 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/timer_entry.sv
// Microwave timer keypad entry: debounced digit capture into a three-digit buffer and a validated load strobe.
// Build option: define TIMER_ENTRY_LOCK_EN to ignore further keys once three digits are held.
module timer_entry #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic [9:0] keys,
   input  logic       start,
   input  logic       cancel,
   input  logic       entry_en,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] mins,
   output logic       loadn,
   output logic       err,
   output logic [1:0] dbg_state
);
   // No valid/ready handshakes here: keys/start/cancel are levels sampled on every rising edge,
   // and loadn/err are registered single-cycle strobes toward the counter chain.

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      LOAD     = 2'd3
   } state_t;

`ifdef TIMER_ENTRY_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   // db_cnt counts samples already taken, so the accepting edge is the one that sees DB_LAST.
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [9:0] code_q, code_d;
   logic [3:0] db_cnt_q, db_cnt_d;
   logic [1:0] count_q, count_d;
   logic [3:0] ones_q, ones_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] mins_q, mins_d;
   logic       start_q;
   logic       loadn_q, loadn_d;
   logic       err_q, err_d;
   logic       start_rise;
   logic       key_onehot;
   logic       buf_zero;
   logic       tens_bad;
   logic       do_shift;
   logic [3:0] key_digit;

   assign start_rise = start & ~start_q;
   assign key_onehot = (keys != 10'd0) && ((keys & (keys - 10'd1)) == 10'd0);
   assign buf_zero   = (ones_q == 4'd0) && (tens_q == 4'd0) && (mins_q == 4'd0);
   assign tens_bad   = (tens_q > 4'd5);

   always_comb begin
      key_digit = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (keys[i]) key_digit = 4'(i);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      db_cnt_d = db_cnt_q;
      count_d  = count_q;
      ones_d   = ones_q;
      tens_d   = tens_q;
      mins_d   = mins_q;
      do_shift = 1'b0;
      if (cancel) begin
         state_d  = IDLE;
         db_cnt_d = 4'd0;
         count_d  = 2'd0;
         ones_d   = 4'd0;
         tens_d   = 4'd0;
         mins_d   = 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               // A start edge takes the cycle even when it is refused or ignored.
               if (entry_en && start_rise) begin
                  if (!tens_bad && !buf_zero) state_d = LOAD;
               end else if (entry_en && key_onehot) begin
                  code_d = keys;
                  if (DEBOUNCE_CYCLES == 1) begin
                     do_shift = 1'b1;
                     state_d  = HELD;
                     db_cnt_d = 4'd0;
                  end else begin
                     state_d  = DEBOUNCE;
                     db_cnt_d = 4'd1;
                  end
               end
            end
            DEBOUNCE: begin
               if ((keys != code_q) || !entry_en) begin
                  state_d  = IDLE;
                  db_cnt_d = 4'd0;
               end else if (db_cnt_q == DB_LAST) begin
                  do_shift = 1'b1;
                  state_d  = HELD;
                  db_cnt_d = 4'd0;
               end else begin
                  db_cnt_d = db_cnt_q + 4'd1;
               end
            end
            HELD: begin
               if (keys == 10'd0) state_d = IDLE;
            end
            LOAD: begin
               state_d = IDLE;
               count_d = 2'd0;
               ones_d  = 4'd0;
               tens_d  = 4'd0;
               mins_d  = 4'd0;
            end
            default: state_d = IDLE;
         endcase
         if (do_shift && !(LOCK_EN && (count_q == 2'd3))) begin
            mins_d = tens_q;
            tens_d = ones_q;
            ones_d = key_digit;
            if (count_q != 2'd3) count_d = count_q + 2'd1;
         end
      end
   end

   always_comb begin
      loadn_d = (state_d != LOAD);
      err_d   = !cancel && (state_q == IDLE) && entry_en && start_rise && tens_bad;
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         code_q   <= 10'd0;
         db_cnt_q <= 4'd0;
         count_q  <= 2'd0;
         ones_q   <= 4'd0;
         tens_q   <= 4'd0;
         mins_q   <= 4'd0;
         start_q  <= 1'b0;
         loadn_q  <= 1'b1;
         err_q    <= 1'b0;
      end else begin
         code_q   <= code_d;
         db_cnt_q <= db_cnt_d;
         count_q  <= count_d;
         ones_q   <= ones_d;
         tens_q   <= tens_d;
         mins_q   <= mins_d;
         start_q  <= start;
         loadn_q  <= loadn_d;
         err_q    <= err_d;
      end
   end

   assign sec_ones  = ones_q;
   assign sec_tens  = tens_q;
   assign mins      = mins_q;
   assign loadn     = loadn_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_timer_entry.sv
// Bench for timer_entry: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a press-level model of the keypad entry stage.
module tb_timer_entry;
   localparam int DC = 4;
`ifdef TIMER_ENTRY_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       clk;
   logic       clrn;
   logic [9:0] keys;
   logic       start;
   logic       cancel;
   logic       entry_en;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] mins;
   logic       loadn;
   logic       err;
   logic [1:0] dbg_state;

   int n_checks = 0;
   int n_errors = 0;
   bit started  = 1'b0;

   timer_entry #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk      (clk),
      .clrn     (clrn),
      .keys     (keys),
      .start    (start),
      .cancel   (cancel),
      .entry_en (entry_en),
      .sec_ones (sec_ones),
      .sec_tens (sec_tens),
      .mins     (mins),
      .loadn    (loadn),
      .err      (err),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   // Buffer kept as a queue: front = minutes, back = units of seconds.
   int         m_buf[$] = '{0, 0, 0};
   int         m_cnt = 0;
   int         m_run = 0;           // consecutive identical samples of the current press, 0 = none
   logic [9:0] m_code = '0;
   bit         m_wait_rel = 1'b0;   // digit taken, waiting for all keys up
   bit         m_load = 1'b0;       // load strobe visible this cycle
   bit         m_err = 1'b0;
   bit         m_start_prev = 1'b0;
   bit         m_rise = 1'b0;

   function automatic int digit_of(input logic [9:0] k);
      for (int i = 0; i < 10; i++) if (k[i]) return i;
      return 0;
   endfunction

   task automatic m_clear();
      m_buf = '{0, 0, 0};
      m_cnt = 0;
   endtask

   task automatic m_accept(input int d);
      if (LOCK && m_cnt == 3) return;
      m_buf.push_back(d);
      void'(m_buf.pop_front());
      if (m_cnt < 3) m_cnt++;
   endtask

   task automatic m_count_sample();
      m_run++;
      if (m_run == DC) begin
         m_accept(digit_of(m_code));
         m_run = 0;
         m_wait_rel = 1'b1;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge clrn);
         if (!clrn) begin
            m_clear();
            m_run = 0; m_wait_rel = 0; m_load = 0; m_err = 0; m_start_prev = 0;
         end else begin
            m_rise = start && !m_start_prev;
            m_start_prev = start;
            m_err = 1'b0;
            if (cancel) begin
               m_clear();
               m_run = 0; m_wait_rel = 0; m_load = 0;
            end else if (m_load) begin
               m_load = 0;
               m_clear();
            end else if (m_wait_rel) begin
               if (keys == 10'd0) m_wait_rel = 0;
            end else if (m_run > 0) begin
               if (keys != m_code || !entry_en) m_run = 0;
               else m_count_sample();
            end else if (entry_en && m_rise) begin
               if (m_buf[1] > 5) m_err = 1'b1;
               else if (m_buf[0] + m_buf[1] + m_buf[2] != 0) m_load = 1'b1;
            end else if (entry_en && $countones(keys) == 1) begin
               m_code = keys;
               m_run = 0;
               m_count_sample();
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            check("model_mins", 32'(mins), 32'(m_buf[0]));
            check("model_sec_tens", 32'(sec_tens), 32'(m_buf[1]));
            check("model_sec_ones", 32'(sec_ones), 32'(m_buf[2]));
            check("model_loadn", 32'(loadn), 32'(!m_load));
            check("model_err", 32'(err), 32'(m_err));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic press(input int d, input int n);
      @(negedge clk);
      keys = 10'd0;
      keys[d] = 1'b1;
      repeat (n) @(negedge clk);
      keys = 10'd0;
      repeat (1) @(negedge clk);
   endtask

   task automatic do_cancel();
      @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
   endtask

   task automatic check_buf(input string name, input int m, input int t, input int o);
      check({name, "_mins"}, 32'(mins), 32'(m));
      check({name, "_tens"}, 32'(sec_tens), 32'(t));
      check({name, "_ones"}, 32'(sec_ones), 32'(o));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int hold;
      int r;
      clrn = 1'b1; keys = '0; start = 0; cancel = 0; entry_en = 1'b1;
      #1 clrn = 1'b0;
      started = 1'b1;
      repeat (3) @(negedge clk);
      check_buf("reset", 0, 0, 0);
      check("reset_loadn", 32'(loadn), 32'd1);
      check("reset_err", 32'(err), 32'd0);
      clrn = 1'b1;

      // 1, 3, 0 then start: one-cycle strobe right after the sampling edge, then cleared
      press(1, 6); press(3, 6); press(0, 6);
      check_buf("entry130", 1, 3, 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      check("load_strobe_low", 32'(loadn), 32'd0);
      check_buf("load_stable", 1, 3, 0);
      start = 1'b0;
      @(negedge clk);
      check("load_strobe_high", 32'(loadn), 32'd1);
      check_buf("after_load", 0, 0, 0);

      // debounce: a 2-cycle glitch is dropped, a 4-cycle press is taken, a long press once
      press(5, 2);
      check_buf("glitch", 0, 0, 0);
      press(5, 4);
      check_buf("press4", 0, 0, 5);
      do_cancel();
      press(5, 100);
      check_buf("press100", 0, 0, 5);
      do_cancel();

      // tens digit above 5 is refused with err, buffer kept; cancel clears
      press(1, 6); press(7, 6); press(5, 6);
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      check("err_pulse", 32'(err), 32'd1);
      check("err_no_load", 32'(loadn), 32'd1);
      start = 1'b0;
      @(negedge clk);
      check("err_one_cycle", 32'(err), 32'd0);
      check_buf("err_kept", 1, 7, 5);
      do_cancel();
      check_buf("cancelled", 0, 0, 0);

      // two keys at once, and keys while entry is disabled, are ignored
      @(negedge clk); keys = 10'b00_0000_1100;
      repeat (6) @(negedge clk);
      keys = '0;
      @(negedge clk);
      check_buf("multikey", 0, 0, 0);
      entry_en = 1'b0;
      press(4, 6);
      check_buf("entry_disabled", 0, 0, 0);
      entry_en = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk);
      check("empty_start_loadn", 32'(loadn), 32'd1);
      check("empty_start_err", 32'(err), 32'd0);
      start = 1'b0;
      @(negedge clk);

      // fourth digit
      press(9, 6); press(8, 6); press(4, 6); press(2, 6);
      if (LOCK) check_buf("four_digits", 9, 8, 4);
      else      check_buf("four_digits", 8, 4, 2);
      do_cancel();

      // asynchronous reset in the load cycle
      press(1, 6);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      #2 clrn = 1'b0;
      #1;
      check("async_loadn", 32'(loadn), 32'd1);
      check_buf("async_clear", 0, 0, 0);
      @(negedge clk);
      start = 1'b0;
      clrn = 1'b1;

      // randomized traffic, checked every cycle by the model
      hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (hold == 0) begin
            hold = $urandom_range(1, 8);
            r = $urandom_range(0, 9);
            if (r < 4)      keys = 10'd0;
            else if (r < 9) keys = 10'd1 << $urandom_range(0, 9);
            else            keys = 10'($urandom);
         end
         hold--;
         if ($urandom_range(0, 5) == 0) start = ~start;
         cancel   = ($urandom_range(0, 40) == 0);
         entry_en = ($urandom_range(0, 15) != 0);
      end
      @(negedge clk);
      keys = '0; start = 0; cancel = 0; entry_en = 1'b1;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
